// File: rtl/gcd_stein_core_if.sv
// Operand/result bundle between the pin wrapper and the Stein GCD core.
// The wrapper drives the master side; the core implements the slave side.
interface gcd_stein_core_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
);
    logic             req;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ack;
    logic             busy;
    logic [WIDTH-1:0] gcd_out;
    logic [CNT_W-1:0] cycles;
    logic             zero_flag;

    modport master (
        output req, a_in, b_in,
        input  ack, busy, gcd_out, cycles, zero_flag
    );

    modport slave (
        input  req, a_in, b_in,
        output ack, busy, gcd_out, cycles, zero_flag
    );
endinterface

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD engine: one reduction step per clock, four-phase req/ack.
// Zero operands bypass the reduction loop; the step count saturates.
module gcd_stein_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    gcd_stein_core_if.slave   bus
);
    localparam int unsigned K_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [K_W-1:0]   k_q;
    logic [WIDTH-1:0] gcd_q;
    logic [CNT_W-1:0] cycles_q;
    logic             ack_q;
    logic             busy_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [K_W-1:0]   k_d;
    logic [CNT_W-1:0] cycles_d;
    logic [WIDTH-1:0] gcd_d;

    // One reduction step; the a==b terminating case is handled in the FSM.
    // The larger operand is always the minuend, so the subtraction cannot borrow.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        k_d = k_q;
        if (!a_q[0] && !b_q[0]) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            k_d = k_q + K_W'(1);
        end else if (!a_q[0]) begin
            a_d = a_q >> 1;
        end else if (!b_q[0]) begin
            b_d = b_q >> 1;
        end else if (a_q > b_q) begin
            a_d = (a_q - b_q) >> 1;
        end else begin
            b_d = (b_q - a_q) >> 1;
        end
    end

    always_comb begin
        cycles_d = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_W'(1);
        gcd_d    = a_q << k_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            gcd_q    <= '0;
            cycles_q <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req && !ack_q) begin
                        a_q      <= bus.a_in;
                        b_q      <= bus.b_in;
                        k_q      <= '0;
                        cycles_q <= '0;
                        zero_q   <= 1'b0;
                        if (bus.a_in == '0 || bus.b_in == '0) begin
                            gcd_q   <= bus.a_in | bus.b_in;
                            zero_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    cycles_q <= cycles_d;
                    if (a_q == b_q) begin
                        gcd_q   <= gcd_d;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        a_q <= a_d;
                        b_q <= b_d;
                        k_q <= k_d;
                    end
                end
                DONE: begin
                    // ack rises on the first DONE edge regardless of req, so a
                    // request withdrawn during CALC still sees a one-cycle pulse.
                    if (!ack_q) begin
                        ack_q <= 1'b1;
                    end else if (!bus.req) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.gcd_out   = gcd_q;
    assign bus.cycles    = cycles_q;
    assign bus.zero_flag = zero_q;
endmodule

// File: tb/tb_gcd_stein_core.sv
// Self-checking bench for gcd_stein_core: directed vectors on 8-bit cores and a
// randomized 16-bit sweep against an arithmetic reference model.
module tb_gcd_stein_core;
    logic clk;
    logic rst_n;

    gcd_stein_core_if #(.WIDTH(8),  .CNT_W(5)) bus8 ();
    gcd_stein_core_if #(.WIDTH(8),  .CNT_W(3)) bus3 ();
    gcd_stein_core_if #(.WIDTH(16), .CNT_W(5)) bus16 ();

    gcd_stein_core #(.WIDTH(8),  .CNT_W(5)) u_d8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    gcd_stein_core #(.WIDTH(8),  .CNT_W(3)) u_d3  (.clk(clk), .rst_n(rst_n), .bus(bus3));
    gcd_stein_core #(.WIDTH(16), .CNT_W(5)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int          sel;
    logic        ack_s;
    logic        busy_s;
    logic [15:0] gcd_s;
    logic [4:0]  cyc_s;
    logic        zf_s;

    always_comb begin
        ack_s  = 1'b0;
        busy_s = 1'b0;
        gcd_s  = '0;
        cyc_s  = '0;
        zf_s   = 1'b0;
        case (sel)
            0: begin
                ack_s = bus8.ack;  busy_s = bus8.busy;  gcd_s = {8'd0, bus8.gcd_out};
                cyc_s = bus8.cycles; zf_s = bus8.zero_flag;
            end
            1: begin
                ack_s = bus3.ack;  busy_s = bus3.busy;  gcd_s = {8'd0, bus3.gcd_out};
                cyc_s = {2'd0, bus3.cycles}; zf_s = bus3.zero_flag;
            end
            default: begin
                ack_s = bus16.ack; busy_s = bus16.busy; gcd_s = bus16.gcd_out;
                cyc_s = bus16.cycles; zf_s = bus16.zero_flag;
            end
        endcase
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int s, input logic r, input logic [15:0] a, input logic [15:0] b);
        case (s)
            0: begin bus8.req = r;  bus8.a_in = a[7:0];  bus8.b_in = b[7:0];  end
            1: begin bus3.req = r;  bus3.a_in = a[7:0];  bus3.b_in = b[7:0];  end
            default: begin bus16.req = r; bus16.a_in = a; bus16.b_in = b; end
        endcase
    endtask

    // Reference: gcd by Euclid; step count by walking Stein's rules on integers.
    task automatic ref_model(input int unsigned a, input int unsigned b,
                             output int unsigned g, output int unsigned steps, output int unsigned zf);
        int unsigned x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        g = x;
        steps = 0;
        zf = (a == 0 || b == 0) ? 1 : 0;
        if (zf == 0) begin
            x = a; y = b;
            for (int i = 0; i < 1000; i++) begin
                steps++;
                if (x == y) break;
                if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
                else if (x % 2 == 0) x = x / 2;
                else if (y % 2 == 0) y = y / 2;
                else if (x > y) x = (x - y) / 2;
                else y = (y - x) / 2;
            end
        end
    endtask

    task automatic do_op(input int s, input logic [15:0] a, input logic [15:0] b, input bit hold,
                         output int unsigned g, output int unsigned cyc, output int unsigned zf,
                         output int unsigned lat, output int unsigned bcnt, output int unsigned fall,
                         output bit stay_ok, output bit timeout);
        sel = s;
        @(negedge clk);
        set_in(s, 1'b1, a, b);
        @(posedge clk); #1;
        bcnt = busy_s;
        lat = 0;
        timeout = 1'b1;
        if (!hold) begin
            @(negedge clk);
            set_in(s, 1'b0, 16'($urandom), 16'($urandom));
        end
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack_s) begin timeout = 1'b0; break; end
            bcnt += busy_s;
        end
        g = gcd_s; cyc = cyc_s; zf = zf_s;
        stay_ok = 1'b1;
        if (hold) begin
            repeat (2) begin
                @(posedge clk); #1;
                if (!ack_s) stay_ok = 1'b0;
            end
            @(negedge clk);
            set_in(s, 1'b0, '0, '0);
        end
        fall = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            fall++;
            if (!ack_s) break;
        end
    endtask

    typedef struct {
        int          s;
        logic [15:0] a;
        logic [15:0] b;
        bit          hold;
        int unsigned gcd;
        int unsigned cyc;
        int unsigned zf;
        int unsigned lat;
    } vec_t;

    vec_t vecs[11];

    task automatic run_and_check(input string tag, input int s, input logic [15:0] a, input logic [15:0] b,
                                 input bit hold, input int unsigned eg, input int unsigned ec,
                                 input int unsigned ez, input int unsigned el);
        int unsigned g, c, z, l, bc, f;
        bit st, to;
        do_op(s, a, b, hold, g, c, z, l, bc, f, st, to);
        chk({tag, " timeout"}, to, 0);
        chk({tag, " gcd"}, g, eg);
        chk({tag, " cycles"}, c, ec);
        chk({tag, " zero_flag"}, z, ez);
        chk({tag, " latency"}, l, el);
        chk({tag, " busy_cycles"}, bc, el - 1);
        chk({tag, " ack_fall"}, f, 1);
        if (hold) chk({tag, " ack_held"}, st, 1);
    endtask

    initial begin
        int unsigned g, c, z, st;
        logic [15:0] ra, rb;
        bit h;

        sel = 0;
        set_in(0, 1'b0, '0, '0);
        set_in(1, 1'b0, '0, '0);
        set_in(2, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", bus8.ack, 0);
        chk("reset busy", bus8.busy, 0);
        chk("reset gcd", bus8.gcd_out, 0);
        chk("reset cycles", bus8.cycles, 0);
        chk("reset zero_flag", bus8.zero_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //           sel  a      b     hold gcd  cyc zf lat
        vecs[0]  = '{0, 16'd48,  16'd18,  1, 6,   6, 0, 7};
        vecs[1]  = '{0, 16'd6,   16'd6,   1, 6,   1, 0, 2};
        vecs[2]  = '{0, 16'd0,   16'd35,  1, 35,  0, 1, 1};
        vecs[3]  = '{0, 16'd0,   16'd0,   1, 0,   0, 1, 1};
        vecs[4]  = '{1, 16'd255, 16'd1,   1, 1,   7, 0, 9};
        vecs[5]  = '{0, 16'd255, 16'd1,   1, 1,   8, 0, 9};
        vecs[6]  = '{0, 16'd35,  16'd0,   0, 35,  0, 1, 1};
        vecs[7]  = '{0, 16'd128, 16'd64,  1, 64,  8, 0, 9};
        vecs[8]  = '{0, 16'd7,   16'd5,   1, 1,   4, 0, 5};
        vecs[9]  = '{0, 16'd255, 16'd255, 1, 255, 1, 0, 2};
        vecs[10] = '{0, 16'd48,  16'd18,  0, 6,   6, 0, 7};

        foreach (vecs[i]) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].hold,
                          vecs[i].gcd, vecs[i].cyc, vecs[i].zf, vecs[i].lat);
        end

        // Abort mid-CALC with an asynchronous reset, then a clean operation.
        sel = 0;
        @(negedge clk);
        set_in(0, 1'b1, 16'd48, 16'd18);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre-abort busy", bus8.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort ack", bus8.ack, 0);
        chk("abort busy", bus8.busy, 0);
        chk("abort gcd", bus8.gcd_out, 0);
        chk("abort cycles", bus8.cycles, 0);
        chk("abort zero_flag", bus8.zero_flag, 0);
        set_in(0, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no stale ack", bus8.ack, 0);
        run_and_check("post-reset", 0, 16'd21, 16'd14, 1, 7, 3, 0, 4);

        // Randomized 16-bit sweep.
        for (int n = 0; n < 60; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ra = '0;
            if ($urandom_range(0, 9) == 0) rb = '0;
            if ($urandom_range(0, 3) == 0) begin
                st = $urandom_range(1, 6);
                ra = ra << st;
                rb = rb << st;
            end
            h = 1'($urandom_range(0, 1));
            ref_model(ra, rb, g, c, z);
            run_and_check($sformatf("rnd%0d a=%0d b=%0d", n, ra, rb), 2, ra, rb, h,
                          g, (c > 31) ? 31 : c, z, (z != 0) ? 1 : c + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
